// File: rtl/alu_arbiter_if.sv
// Requester/response handshakes plus the registered-ALU bus of the shared-ALU arbiter.
// The arbiter binds to slave; requesters and the ALU together form the master side.
interface alu_arbiter_if #(parameter int W = 32);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_din_0;
  logic [2*W-1:0] req_din_1;
  logic [7:0]     req_ctrl;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_result;
  logic           rsp_err;
  logic [W-1:0]   alu_din_0;
  logic [W-1:0]   alu_din_1;
  logic [3:0]     alu_ctrl;
  logic [W-1:0]   alu_result;

  modport slave (
    input  req_valid, req_din_0, req_din_1, req_ctrl, rsp_ready, alu_result,
    output req_ready, rsp_valid, rsp_result, rsp_err, alu_din_0, alu_din_1, alu_ctrl
  );

  modport master (
    output req_valid, req_din_0, req_din_1, req_ctrl, rsp_ready, alu_result,
    input  req_ready, rsp_valid, rsp_result, rsp_err, alu_din_0, alu_din_1, alu_ctrl
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one registered ALU between two requesters; legal op responds 3 cycles
// after accept, illegal op 1 cycle; a held response blocks further accepts until consumed.
module alu_arbiter #(
  parameter int W = 32
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t       state, state_nxt;
  logic         prio;
  logic         owner;
  logic         winner;
  logic         accept;
  logic         win_legal;
  logic [3:0]   win_ctrl;
  logic [W-1:0] win_din_0;
  logic [W-1:0] win_din_1;
  logic [W-1:0] din_0_q;
  logic [W-1:0] din_1_q;
  logic [3:0]   ctrl_q;
  logic [W-1:0] result_q;
  logic         err_q;

  function automatic logic is_legal(input logic [3:0] c);
    return (c[3] == 1'b0) || (c == 4'b1101);
  endfunction

  // prio only breaks ties; a lone requester always wins
  assign winner    = (&bus.req_valid) ? prio : bus.req_valid[1];
  assign win_din_0 = winner ? bus.req_din_0[W +: W] : bus.req_din_0[0 +: W];
  assign win_din_1 = winner ? bus.req_din_1[W +: W] : bus.req_din_1[0 +: W];
  assign win_ctrl  = winner ? bus.req_ctrl[7:4] : bus.req_ctrl[3:0];
  assign win_legal = is_legal(win_ctrl);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    case (state)
      IDLE: accept = |bus.req_valid;
      EXEC: state_nxt = CAPT;
      CAPT: state_nxt = RESP;
      RESP: begin
        bus.rsp_valid[owner] = 1'b1;
        if (bus.rsp_ready[owner]) begin
          state_nxt = IDLE;
          accept    = |bus.req_valid;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      state_nxt             = win_legal ? EXEC : RESP;
      bus.req_ready[winner] = 1'b1;
    end
    if (reset) begin
      accept        = 1'b0;
      bus.req_ready = 2'b00;
      bus.rsp_valid = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio     <= 1'b0;
      owner    <= 1'b0;
      din_0_q  <= '0;
      din_1_q  <= '0;
      ctrl_q   <= 4'b0000;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        prio  <= ~winner;
        owner <= winner;
        // illegal codes never touch the ALU registers; they respond immediately with an error
        if (win_legal) begin
          din_0_q <= win_din_0;
          din_1_q <= win_din_1;
          ctrl_q  <= win_ctrl;
        end else begin
          result_q <= '0;
          err_q    <= 1'b1;
        end
      end
      if (state == CAPT) begin
        result_q <= bus.alu_result;
        err_q    <= 1'b0;
      end
    end
  end

  assign bus.alu_din_0  = din_0_q;
  assign bus.alu_din_1  = din_1_q;
  assign bus.alu_ctrl   = ctrl_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scenarios plus a randomized run scored against a one-op-at-a-time queue model.
module tb_alu_arbiter;
  localparam int W = 32;

  typedef struct {
    logic         owner;
    logic [W-1:0] res;
    logic         err;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if #(.W(W)) bus();
  alu_arbiter #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Behavioural registered ALU: ADD SLL SLT SLTU XOR SRL OR AND, SRA on 1101
  function automatic logic [W-1:0] alu_ref(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    sa = a;
    case (c)
      4'd0:    return a + b;
      4'd1:    return a << b[4:0];
      4'd2:    return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd3:    return (a < b) ? 1 : 0;
      4'd4:    return a ^ b;
      4'd5:    return a >> b[4:0];
      4'd6:    return a | b;
      4'd7:    return a & b;
      4'd13:   return sa >>> b[4:0];
      default: return '1;
    endcase
  endfunction

  always @(posedge clk) bus.alu_result <= alu_ref(bus.alu_ctrl, bus.alu_din_0, bus.alu_din_1);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req_valid = 2'b00;
    bus.req_din_0 = '0;
    bus.req_din_1 = '0;
    bus.req_ctrl  = 8'h00;
    bus.rsp_ready = 2'b00;
  endtask

  task automatic set_req(input int i, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid[i]       = 1'b1;
    bus.req_din_0[i*W +: W] = a;
    bus.req_din_1[i*W +: W] = b;
    bus.req_ctrl[i*4 +: 4]  = c;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    set_req(0, 4'd0, 32'd1, 32'd2);
    set_req(1, 4'd0, 32'd3, 32'd4);
    sample();
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
    step();
    reset = 1'b0;
    idle_inputs();
    sample();
    n_checks++; if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_handshakes: rsp_valid=%b req_ready=%b expected 00/00", bus.rsp_valid, bus.req_ready); end
    n_checks++; if (bus.rsp_result !== '0 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: result=%h err=%b expected 0/0", bus.rsp_result, bus.rsp_err); end
    n_checks++; if (bus.alu_din_0 !== '0 || bus.alu_din_1 !== '0 || bus.alu_ctrl !== 4'b0000) begin n_fail++; $display("FAIL reset_alu: din0=%h din1=%h ctrl=%b expected 0", bus.alu_din_0, bus.alu_din_1, bus.alu_ctrl); end
    step();
  endtask

  task automatic test_single_add();
    do_reset();
    set_req(0, 4'b0000, 32'd5, 32'hFFFF_FFFD);
    sample();
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL add_grant: got %b expected 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) bus.rsp_ready = 2'b01;
      sample();
      if (k == 1) begin
        n_checks++; if (bus.alu_din_0 !== 32'd5 || bus.alu_din_1 !== 32'hFFFF_FFFD || bus.alu_ctrl !== 4'b0000) begin n_fail++; $display("FAIL add_alu_inputs: din0=%h din1=%h ctrl=%b expected 5/fffffffd/0000", bus.alu_din_0, bus.alu_din_1, bus.alu_ctrl); end
      end
      if (k < 3) begin
        n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL add_early_rsp: T+%0d rsp_valid=%b expected 00", k, bus.rsp_valid); end
      end else begin
        n_checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd2 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL add_rsp: rsp_valid=%b result=%h err=%b expected 01/2/0", bus.rsp_valid, bus.rsp_result, bus.rsp_err); end
      end
      step();
    end
    bus.rsp_ready = 2'b00;
    sample();
    n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL add_consumed: rsp_valid=%b expected 00", bus.rsp_valid); end
    step();
  endtask

  task automatic test_contention();
    logic q[$];
    logic exp_g;
    int   last_t;
    int   ngrant;
    do_reset();
    set_req(0, 4'b0010, 32'hFFFF_FFFF, 32'd1);
    set_req(1, 4'b0011, 32'hFFFF_FFFF, 32'd1);
    bus.rsp_ready = 2'b11;
    exp_g  = 1'b0;
    last_t = -1;
    ngrant = 0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (bus.rsp_valid !== 2'b00) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL cont_rsp_spurious: rsp_valid=%b expected 00", bus.rsp_valid);
        end else if (bus.rsp_valid !== (2'b01 << q[0]) || bus.rsp_result !== (q[0] ? 32'd0 : 32'd1) || bus.rsp_err !== 1'b0) begin
          n_fail++; $display("FAIL cont_rsp: rsp_valid=%b result=%h err=%b expected owner r%0d result %0d", bus.rsp_valid, bus.rsp_result, bus.rsp_err, q[0], q[0] ? 0 : 1);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (bus.req_ready !== 2'b00) begin
        n_checks++; if (bus.req_ready !== (2'b01 << exp_g)) begin n_fail++; $display("FAIL cont_grant: got %b expected r%0d", bus.req_ready, exp_g); end
        if (last_t >= 0) begin
          n_checks++; if (cyc - last_t != 3) begin n_fail++; $display("FAIL cont_interval: got %0d expected 3", cyc - last_t); end
        end
        last_t = cyc;
        q.push_back(exp_g);
        exp_g = ~exp_g;
        ngrant++;
      end
      step();
    end
    n_checks++; if (ngrant != 7) begin n_fail++; $display("FAIL cont_grant_count: got %0d expected 7", ngrant); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(1, 4'b1101, 32'h8000_0000, 32'd4);
    sample();
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_r1_grant: got %b expected 10", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    set_req(0, 4'b0111, 32'h0000_F0F0, 32'h0000_FF00);
    for (int k = 1; k <= 7; k++) begin
      sample();
      n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_r0_early: T+%0d req_ready=%b expected 00", k, bus.req_ready); end
      if (k >= 3) begin
        n_checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 32'hF800_0000 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp_hold: T+%0d rsp_valid=%b result=%h err=%b expected 10/f8000000/0", k, bus.rsp_valid, bus.rsp_result, bus.rsp_err); end
      end
      step();
    end
    bus.rsp_ready = 2'b10;
    sample();
    n_checks++; if (bus.rsp_valid !== 2'b10 || bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_handshake_accept: rsp_valid=%b req_ready=%b expected 10/01", bus.rsp_valid, bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      sample();
      if (k < 3) begin
        n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL bp_r0_early_rsp: rsp_valid=%b expected 00", bus.rsp_valid); end
      end else begin
        n_checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'h0000_F000 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp_r0_rsp: rsp_valid=%b result=%h err=%b expected 01/f000/0", bus.rsp_valid, bus.rsp_result, bus.rsp_err); end
      end
      step();
    end
  endtask

  task automatic test_illegal();
    do_reset();
    set_req(0, 4'b0110, 32'h0000_00F0, 32'h0000_0F00);
    bus.rsp_ready = 2'b01;
    sample();
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL ill_pre_grant: got %b expected 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    step();
    step();
    sample();
    n_checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'h0000_0FF0) begin n_fail++; $display("FAIL ill_pre_rsp: rsp_valid=%b result=%h expected 01/ff0", bus.rsp_valid, bus.rsp_result); end
    step();
    bus.rsp_ready = 2'b00;
    set_req(0, 4'b1000, 32'h1234, 32'h5678);
    sample();
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL ill_grant: got %b expected 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    for (int k = 1; k <= 2; k++) begin
      if (k == 2) bus.rsp_ready = 2'b01;
      sample();
      n_checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== '0 || bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL ill_rsp: T+%0d rsp_valid=%b result=%h err=%b expected 01/0/1", k, bus.rsp_valid, bus.rsp_result, bus.rsp_err); end
      n_checks++; if (bus.alu_ctrl !== 4'b0110 || bus.alu_din_0 !== 32'h0000_00F0 || bus.alu_din_1 !== 32'h0000_0F00) begin n_fail++; $display("FAIL ill_alu_hold: ctrl=%b din0=%h din1=%h expected 0110/f0/f00", bus.alu_ctrl, bus.alu_din_0, bus.alu_din_1); end
      step();
    end
    set_req(0, 4'b0100, 32'h0000_00FF, 32'h0000_000F);
    sample();
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL ill_next_grant: got %b expected 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    step();
    step();
    sample();
    n_checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'h0000_00F0 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL ill_next_rsp: rsp_valid=%b result=%h err=%b expected 01/f0/0", bus.rsp_valid, bus.rsp_result, bus.rsp_err); end
    step();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_req(0, 4'b0000, 32'd10, 32'd20);
    bus.rsp_ready = 2'b11;
    sample();
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rmo_grant: got %b expected 01", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    step();
    reset = 1'b1;
    sample();
    n_checks++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rmo_during: req_ready=%b rsp_valid=%b expected 00/00", bus.req_ready, bus.rsp_valid); end
    step();
    reset = 1'b0;
    sample();
    n_checks++; if (bus.rsp_result !== '0 || bus.rsp_err !== 1'b0 || bus.alu_din_0 !== '0 || bus.alu_din_1 !== '0 || bus.alu_ctrl !== 4'b0000) begin n_fail++; $display("FAIL rmo_outputs: result=%h err=%b din0=%h din1=%h ctrl=%b expected all 0", bus.rsp_result, bus.rsp_err, bus.alu_din_0, bus.alu_din_1, bus.alu_ctrl); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) sample();
      n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rmo_no_rsp: cycle %0d rsp_valid=%b expected 00", k, bus.rsp_valid); end
      step();
    end
    set_req(0, 4'b0000, 32'd1, 32'd1);
    set_req(1, 4'b0000, 32'd2, 32'd2);
    sample();
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rmo_prio: got %b expected 01", bus.req_ready); end
    step();
    idle_inputs();
  endtask

  task automatic test_non_owner_ready();
    do_reset();
    set_req(1, 4'b0000, 32'd1, 32'd2);
    sample();
    n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL nor_grant: got %b expected 10", bus.req_ready); end
    step();
    bus.req_valid = 2'b00;
    step();
    step();
    bus.rsp_ready = 2'b01;
    set_req(0, 4'b0000, 32'd3, 32'd4);
    for (int k = 0; k < 3; k++) begin
      sample();
      n_checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 32'd3 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL nor_hold: rsp_valid=%b result=%h req_ready=%b expected 10/3/00", bus.rsp_valid, bus.rsp_result, bus.req_ready); end
      step();
    end
    bus.rsp_ready = 2'b10;
    sample();
    n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL nor_handshake: req_ready=%b expected 01", bus.req_ready); end
    step();
    idle_inputs();
  endtask

  task automatic test_random();
    exp_t         q[$];
    exp_t         e;
    logic [3:0]   c[2];
    logic [W-1:0] a[2];
    logic [W-1:0] b[2];
    logic         pend[2];
    logic         mprio;
    logic         w;
    logic [1:0]   exp_rv;
    logic [1:0]   exp_rr;
    do_reset();
    mprio = 1'b0;
    for (int i = 0; i < 2; i++) pend[i] = 1'b0;
    for (int k = 0; k < 440; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          bus.req_valid[i] = 1'b0;
          if (k < 400 && $urandom_range(0, 2) != 0) begin
            pend[i] = 1'b1;
            c[i] = 4'($urandom_range(0, 15));
            a[i] = $urandom;
            b[i] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
            set_req(i, c[i], a[i], b[i]);
          end
        end
      end
      bus.rsp_ready = (k < 400) ? 2'($urandom_range(0, 3)) : 2'b11;
      sample();
      exp_rv = (q.size() != 0 && cyc >= q[0].due) ? (2'b01 << q[0].owner) : 2'b00;
      n_checks++; if (bus.rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rand_rsp_valid: cycle %0d got %b expected %b", cyc, bus.rsp_valid, exp_rv); end
      if (exp_rv != 2'b00) begin
        n_checks++; if (bus.rsp_result !== q[0].res || bus.rsp_err !== q[0].err) begin n_fail++; $display("FAIL rand_rsp_data: cycle %0d result=%h err=%b expected %h/%b", cyc, bus.rsp_result, bus.rsp_err, q[0].res, q[0].err); end
        if (bus.rsp_ready[q[0].owner]) void'(q.pop_front());
      end
      exp_rr = 2'b00;
      w = 1'b0;
      if (q.size() == 0 && (pend[0] || pend[1])) begin
        w = (pend[0] && pend[1]) ? mprio : pend[1];
        exp_rr = 2'b01 << w;
      end
      n_checks++; if (bus.req_ready !== exp_rr) begin n_fail++; $display("FAIL rand_grant: cycle %0d got %b expected %b", cyc, bus.req_ready, exp_rr); end
      if (exp_rr != 2'b00) begin
        e.owner = w;
        e.err   = !(c[w] inside {[4'd0:4'd7], 4'd13});
        e.res   = e.err ? '0 : alu_ref(c[w], a[w], b[w]);
        e.due   = cyc + (e.err ? 1 : 3);
        q.push_back(e);
        mprio   = ~w;
        pend[w] = 1'b0;
      end
      step();
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_drain: %0d ops outstanding expected 0", q.size()); end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_mid_op();
    test_non_owner_ready();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
